// File: rtl/spi_slave_rhs2116.sv
// SPI Mode 1 responder emulating the RHS2116 sensor end of the acquisition link.
// Oversamples SCLK/CS/MOSI in clk_sys, returns a counter or user word, reports commands.
module spi_slave_rhs2116 #(
    parameter int                DATA_W      = 32,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] COUNT_INIT  = '0
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] resp_data,
    input  logic              resp_valid,
    output logic              resp_ready,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_valid,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;

    state_t            state_q, state_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] counter_q, counter_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic cs_s, sclk_s, mosi_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cs_prev_d   = cs_s;
    assign sclk_prev_d = sclk_s;

    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    always_comb begin
        state_d     = state_q;
        miso_d      = miso_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        ovf_d       = ovf_q;
        counter_d   = counter_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (resp_valid && !hold_full_q) begin
            hold_d      = resp_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = SHIFT;
                    counter_d = counter_q + 1'b1;
                    tx_cnt_d  = '0;
                    rx_cnt_d  = '0;
                    ovf_d     = 1'b0;
                    // Decision uses the hold state from before this edge
                    if (hold_full_q) begin
                        tx_sr_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        tx_sr_d = counter_q + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    miso_d   = 1'b0;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    ovf_d    = 1'b0;
                    if (rx_cnt_q == CW'(DATA_W) && !ovf_q) begin
                        cmd_data_d  = rx_sr_q;
                        cmd_valid_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    if (tx_cnt_q < CW'(DATA_W)) begin
                        miso_d   = tx_sr_q[DATA_W-1];
                        tx_sr_d  = {tx_sr_q[DATA_W-2:0], 1'b0};
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end else begin
                        miso_d = 1'b0;
                        ovf_d  = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (rx_cnt_q < CW'(DATA_W)) begin
                        rx_sr_d  = {rx_sr_q[DATA_W-2:0], mosi_s};
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            miso_q      <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            counter_q   <= COUNT_INIT;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            miso_q      <= miso_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            ovf_q       <= ovf_d;
            counter_q   <= counter_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign miso       = miso_q;
    assign resp_ready = ~hold_full_q;
    assign cmd_data   = cmd_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == SHIFT);
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_spi_slave_rhs2116.sv
// Directed bench for spi_slave_rhs2116: three responders on a shared SCLK/MOSI bus,
// each with its own chip select (default, 8-bit frames, near-wrap counter init).
module tb_spi_slave_rhs2116;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sclk, mosi;
    logic cs_a, cs_b, cs_c;
    logic [31:0] resp_data;
    logic resp_valid;
    logic [7:0] resp_data_b;
    logic resp_valid_b, resp_valid_c;
    logic [31:0] resp_data_c;

    logic miso_a, resp_ready_a, cmd_valid_a, frame_err_a, busy_a;
    logic [31:0] cmd_data_a;
    logic [7:0] frame_cnt_a;
    logic miso_b, resp_ready_b, cmd_valid_b, frame_err_b, busy_b;
    logic [7:0] cmd_data_b;
    logic [7:0] frame_cnt_b;
    logic miso_c, resp_ready_c, cmd_valid_c, frame_err_c, busy_c;
    logic [31:0] cmd_data_c;
    logic [7:0] frame_cnt_c;

    spi_slave_rhs2116 u_dut_a (
        .clk_sys(clk), .rst_n(rst_n), .cs_n(cs_a), .sclk(sclk), .mosi(mosi),
        .miso(miso_a), .resp_data(resp_data), .resp_valid(resp_valid),
        .resp_ready(resp_ready_a), .cmd_data(cmd_data_a), .cmd_valid(cmd_valid_a),
        .frame_err(frame_err_a), .busy(busy_a), .frame_cnt(frame_cnt_a)
    );

    spi_slave_rhs2116 #(.DATA_W(8)) u_dut_b (
        .clk_sys(clk), .rst_n(rst_n), .cs_n(cs_b), .sclk(sclk), .mosi(mosi),
        .miso(miso_b), .resp_data(resp_data_b), .resp_valid(resp_valid_b),
        .resp_ready(resp_ready_b), .cmd_data(cmd_data_b), .cmd_valid(cmd_valid_b),
        .frame_err(frame_err_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
    );

    spi_slave_rhs2116 #(.COUNT_INIT(32'hFFFF_FFFE)) u_dut_c (
        .clk_sys(clk), .rst_n(rst_n), .cs_n(cs_c), .sclk(sclk), .mosi(mosi),
        .miso(miso_c), .resp_data(resp_data_c), .resp_valid(resp_valid_c),
        .resp_ready(resp_ready_c), .cmd_data(cmd_data_c), .cmd_valid(cmd_valid_c),
        .frame_err(frame_err_c), .busy(busy_c), .frame_cnt(frame_cnt_c)
    );

    int errors = 0;
    int checks = 0;
    int cv_a = 0, fe_a = 0, cv_b = 0, fe_b = 0, cv_c = 0, fe_c = 0;

    // Cycle counts of pulse outputs; a stuck-high pulse inflates them
    always @(posedge clk) begin
        if (cmd_valid_a) cv_a <= cv_a + 1;
        if (frame_err_a) fe_a <= fe_a + 1;
        if (cmd_valid_b) cv_b <= cv_b + 1;
        if (frame_err_b) fe_b <= fe_b + 1;
        if (cmd_valid_c) cv_c <= cv_c + 1;
        if (frame_err_c) fe_c <= fe_c + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_cs(input int sel, input logic v);
        case (sel)
            0: cs_a = v;
            1: cs_b = v;
            default: cs_c = v;
        endcase
    endtask

    function automatic logic get_miso(input int sel);
        case (sel)
            0: return miso_a;
            1: return miso_b;
            default: return miso_c;
        endcase
    endfunction

    // Mode 1 master: drive MOSI on rising SCLK, sample MISO just before falling SCLK
    task automatic frame(input int sel, input int nbits, input int dw,
                         input logic [31:0] cmd, output logic [63:0] rx);
        rx = '0;
        @(negedge clk);
        set_cs(sel, 1'b0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i < dw) mosi = cmd[dw-1-i];
            else mosi = 1'b0;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            rx = {rx[62:0], get_miso(sel)};
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        set_cs(sel, 1'b1);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sclk = 1'b0; mosi = 1'b0;
        cs_a = 1'b1; cs_b = 1'b1; cs_c = 1'b1;
        resp_data = '0; resp_valid = 1'b0;
        resp_data_b = '0; resp_valid_b = 1'b0;
        resp_data_c = '0; resp_valid_c = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({miso_a, cmd_valid_a, frame_err_a, busy_a, resp_ready_a} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00001",
                     {miso_a, cmd_valid_a, frame_err_a, busy_a, resp_ready_a});
        end
        checks++;
        if (cmd_data_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_cmd_data: got %h want 00000000", cmd_data_a);
        end
        checks++;
        if (frame_cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt_a);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [63:0] rx;
        logic [31:0] cmd;
        int cv0;
        for (int k = 1; k <= 3; k++) begin
            cmd = 32'hA5A5_0000 | k;
            cv0 = cv_a;
            frame(0, 32, 32, cmd, rx);
            checks++;
            if (rx[31:0] !== k) begin
                errors++;
                $display("FAIL basic_miso%0d: got %h want %h", k, rx[31:0], k);
            end
            checks++;
            if (cmd_data_a !== cmd || cv_a != cv0 + 1) begin
                errors++;
                $display("FAIL basic_cmd%0d: got %h/%0d want %h/%0d",
                         k, cmd_data_a, cv_a - cv0, cmd, 1);
            end
        end
        checks++;
        if (frame_cnt_a !== 8'd3 || fe_a != 0) begin
            errors++;
            $display("FAIL basic_counts: got cnt=%0d err=%0d want cnt=3 err=0",
                     frame_cnt_a, fe_a);
        end
    endtask

    task automatic test_override;
        logic [63:0] rx;
        @(negedge clk);
        resp_data = 32'hDEAD_BEEF;
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        checks++;
        if (resp_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL ovr_ready_low: got %b want 0", resp_ready_a);
        end
        frame(0, 32, 32, 32'h0000_0004, rx);
        checks++;
        if (rx[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ovr_word: got %h want deadbeef", rx[31:0]);
        end
        checks++;
        if (resp_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL ovr_ready_high: got %b want 1", resp_ready_a);
        end
        frame(0, 32, 32, 32'h0000_0005, rx);
        checks++;
        if (rx[31:0] !== 32'd5) begin
            errors++;
            $display("FAIL ovr_next: got %h want 00000005", rx[31:0]);
        end
    endtask

    task automatic test_short;
        logic [63:0] rx;
        logic [31:0] cd0;
        logic [7:0] fc0;
        int fe0, cv0;
        cd0 = cmd_data_a; fc0 = frame_cnt_a; fe0 = fe_a; cv0 = cv_a;
        frame(0, 20, 32, 32'h1234_5678, rx);
        checks++;
        if (fe_a != fe0 + 1 || cv_a != cv0) begin
            errors++;
            $display("FAIL short_pulses: got err=%0d valid=%0d want err=1 valid=0",
                     fe_a - fe0, cv_a - cv0);
        end
        checks++;
        if (cmd_data_a !== cd0 || frame_cnt_a !== fc0) begin
            errors++;
            $display("FAIL short_hold: got %h/%0d want %h/%0d",
                     cmd_data_a, frame_cnt_a, cd0, fc0);
        end
        frame(0, 32, 32, 32'h0BAD_F00D, rx);
        checks++;
        if (rx[31:0] !== 32'd7 || cmd_data_a !== 32'h0BAD_F00D || frame_cnt_a !== fc0 + 8'd1) begin
            errors++;
            $display("FAIL short_recover: got %h/%h/%0d want 00000007/0badf00d/%0d",
                     rx[31:0], cmd_data_a, frame_cnt_a, fc0 + 8'd1);
        end
    endtask

    task automatic test_long;
        logic [63:0] rx;
        logic [31:0] cd0;
        logic [7:0] fc0;
        int fe0;
        cd0 = cmd_data_a; fc0 = frame_cnt_a; fe0 = fe_a;
        frame(0, 34, 32, 32'hCAFE_0034, rx);
        checks++;
        if (rx[33:2] !== 32'd8 || rx[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL long_miso: got %h/%b want 00000008/00", rx[33:2], rx[1:0]);
        end
        checks++;
        if (fe_a != fe0 + 1 || frame_cnt_a !== fc0 || cmd_data_a !== cd0) begin
            errors++;
            $display("FAIL long_err: got err=%0d cnt=%0d cmd=%h want err=1 cnt=%0d cmd=%h",
                     fe_a - fe0, frame_cnt_a, cmd_data_a, fc0, cd0);
        end
    endtask

    task automatic test_count_wrap;
        logic [63:0] rx;
        logic [31:0] exp_c [3];
        exp_c[0] = 32'hFFFF_FFFF;
        exp_c[1] = 32'h0000_0000;
        exp_c[2] = 32'h0000_0001;
        for (int k = 0; k < 3; k++) begin
            frame(2, 32, 32, 32'h5000_0000 | k, rx);
            checks++;
            if (rx[31:0] !== exp_c[k]) begin
                errors++;
                $display("FAIL init_wrap%0d: got %h want %h", k, rx[31:0], exp_c[k]);
            end
        end
        checks++;
        if (frame_cnt_c !== 8'd3 || cmd_data_c !== 32'h5000_0002 || fe_c != 0) begin
            errors++;
            $display("FAIL init_counts: got %0d/%h/%0d want 3/50000002/0",
                     frame_cnt_c, cmd_data_c, fe_c);
        end
        for (int k = 0; k < 256; k++) begin
            frame(1, 8, 8, k, rx);
            if (k == 254) begin
                checks++;
                if (frame_cnt_b !== 8'd255) begin
                    errors++;
                    $display("FAIL cnt_255: got %0d want 255", frame_cnt_b);
                end
            end
        end
        checks++;
        if (frame_cnt_b !== 8'd0 || rx[7:0] !== 8'h00 || cmd_data_b !== 8'hFF) begin
            errors++;
            $display("FAIL cnt_wrap: got %0d/%h/%h want 0/00/ff",
                     frame_cnt_b, rx[7:0], cmd_data_b);
        end
        checks++;
        if (cv_b != 256 || fe_b != 0) begin
            errors++;
            $display("FAIL cnt_pulses: got valid=%0d err=%0d want 256/0", cv_b, fe_b);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] rx;
        int fe0, cv0;
        @(negedge clk);
        cs_a = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            mosi = i[0];
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy_a);
        end
        rst_n = 1'b0;
        @(negedge clk);
        sclk = 1'b0; cs_a = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({miso_a, cmd_valid_a, frame_err_a, busy_a, resp_ready_a} !== 5'b00001 ||
            cmd_data_a !== 32'h0 || frame_cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_vals: got %b/%h/%0d want 00001/00000000/0",
                     {miso_a, cmd_valid_a, frame_err_a, busy_a, resp_ready_a},
                     cmd_data_a, frame_cnt_a);
        end
        fe0 = fe_a; cv0 = cv_a;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (fe_a != fe0 || cv_a != cv0) begin
            errors++;
            $display("FAIL mid_no_pulse: got err=%0d valid=%0d want 0/0",
                     fe_a - fe0, cv_a - cv0);
        end
        frame(0, 32, 32, 32'hA5A5_0005, rx);
        checks++;
        if (rx[31:0] !== 32'd1 || cmd_data_a !== 32'hA5A5_0005 || frame_cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL mid_recover: got %h/%h/%0d want 00000001/a5a50005/1",
                     rx[31:0], cmd_data_a, frame_cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_override();
        test_short();
        test_long();
        test_count_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
